// File: rtl/axis_packet_merge.sv
// AXI-Stream packet merge: locks onto one channel at its routing header
// and forwards the whole packet through a one-flit output register.
package axis_packet_merge_pkg;
  localparam int AXIS_DATA_W = 32;
  localparam int AXIS_ID_W   = 4;
  localparam int AXIS_DEST_W = 4;
  localparam int AXIS_USER_W = 4;

  localparam logic [AXIS_ID_W-1:0] ROUTING_HEADER = 4'hF;

  typedef struct packed {
    logic [AXIS_DATA_W-1:0] tdata;
    logic [AXIS_ID_W-1:0]   tid;
    logic [AXIS_DEST_W-1:0] tdest;
    logic [AXIS_USER_W-1:0] tuser;
    logic                   tlast;
  } axis_data_t;
endpackage

module axis_packet_merge
  import axis_packet_merge_pkg::*;
#(
  parameter int DATA_WIDTH           = AXIS_DATA_W,
  parameter int ID_WIDTH             = AXIS_ID_W,
  parameter int DEST_WIDTH           = AXIS_DEST_W,
  parameter int USER_WIDTH           = AXIS_USER_W,
  parameter int CHANNEL_NUMBER       = 10,
  parameter int CHANNEL_NUMBER_WIDTH = $clog2(CHANNEL_NUMBER)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  axis_data_t                      in [CHANNEL_NUMBER],
  input  logic                            in_valid [CHANNEL_NUMBER],
  output logic                            in_ready [CHANNEL_NUMBER],
  output axis_data_t                      out,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [CHANNEL_NUMBER_WIDTH-1:0] current_grant,
  output logic [7:0]                      drop_cnt
);

  localparam int CW = CHANNEL_NUMBER_WIDTH;

  // The flit layout is shared through the package; widths must agree.
  if (DATA_WIDTH != AXIS_DATA_W || ID_WIDTH != AXIS_ID_W ||
      DEST_WIDTH != AXIS_DEST_W || USER_WIDTH != AXIS_USER_W)
  begin : g_width_chk
    $error("axis_data_t widths differ from module parameters");
  end

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] grant_q, grant_d;
  axis_data_t    out_q, out_d;
  logic          out_valid_q, out_valid_d;
  logic [7:0]    drop_q, drop_d;

  logic [CHANNEL_NUMBER-1:0] req;
  logic [CHANNEL_NUMBER-1:0] stray;
  logic                      any_req;
  logic [CW-1:0]             pick;
  logic [CW-1:0]             idx;
  logic [7:0]                n_drop;
  logic [8:0]                drop_sum;
  logic                      take;
  axis_data_t                flit;

  always_comb begin
    for (int i = 0; i < CHANNEL_NUMBER; i++) begin
      req[i]   = in_valid[i] && (in[i].tid == ROUTING_HEADER);
      stray[i] = in_valid[i] && (in[i].tid != ROUTING_HEADER);
    end
  end

  // Round robin starting one past the last grant, wrapping at N-1.
  always_comb begin
    any_req = 1'b0;
    pick    = grant_q;
    idx     = grant_q;
    for (int k = 0; k < CHANNEL_NUMBER; k++) begin
      idx = (idx == CW'(CHANNEL_NUMBER - 1)) ? '0 : idx + CW'(1);
      if (!any_req && req[idx]) begin
        any_req = 1'b1;
        pick    = idx;
      end
    end
  end

  always_comb begin
    n_drop = '0;
    for (int i = 0; i < CHANNEL_NUMBER; i++) begin
      n_drop = n_drop + 8'(stray[i]);
    end
    drop_sum = {1'b0, drop_q} + {1'b0, n_drop};
  end

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    out_d       = out_q;
    out_valid_d = out_valid_q;
    drop_d      = drop_q;
    flit        = in[grant_q];
    take        = 1'b0;
    for (int i = 0; i < CHANNEL_NUMBER; i++) begin
      in_ready[i] = 1'b0;
    end
    if (!rst) begin
      unique case (state_q)
        IDLE: begin
          for (int i = 0; i < CHANNEL_NUMBER; i++) begin
            in_ready[i] = stray[i];
          end
          drop_d = drop_sum[8] ? 8'hFF : drop_sum[7:0];
          if (any_req) begin
            state_d = LOCKED;
            grant_d = pick;
          end
        end
        LOCKED: begin
          in_ready[grant_q] = !out_valid_q || out_ready;
          take = in_ready[grant_q] && in_valid[grant_q];
          if (take && flit.tlast) begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
    if (take) begin
      out_d       = flit;
      out_valid_d = 1'b1;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      grant_q     <= CW'(CHANNEL_NUMBER - 1);
      out_q       <= '0;
      out_valid_q <= 1'b0;
      drop_q      <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      drop_q      <= drop_d;
    end
  end

  assign out           = out_q;
  assign out_valid     = out_valid_q;
  assign current_grant = grant_q;
  assign drop_cnt      = drop_q;

endmodule

// File: tb/tb_axis_packet_merge.sv
// Directed bench for axis_packet_merge: cycle table plus
// stall, saturation, reset and wrap sequences.
module tb_axis_packet_merge;
  import axis_packet_merge_pkg::*;

  localparam int N = 10;

  logic       clk = 1'b0;
  logic       rst;
  axis_data_t in_s [N];
  logic       in_valid [N];
  logic       in_ready [N];
  axis_data_t out;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] current_grant;
  logic [7:0] drop_cnt;
  logic [N-1:0] rdy;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [N-1:0] v;
    logic [N-1:0] h;
    logic [N-1:0] l;
    logic [15:0]  d;
    logic         o;
    logic [N-1:0] e_rdy;
    logic         e_vld;
    logic [31:0]  e_dat;
    logic         e_last;
    logic [3:0]   e_gnt;
    logic [7:0]   e_drop;
  } vec_t;

  vec_t tbl [20];

  axis_packet_merge dut (
    .clk          (clk),
    .rst          (rst),
    .in           (in_s),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .out          (out),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .current_grant(current_grant),
    .drop_cnt     (drop_cnt)
  );

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < N; i++) rdy[i] = in_ready[i];
  end

  task automatic drive(
    input logic [N-1:0] v, input logic [N-1:0] h,
    input logic [N-1:0] l, input logic [15:0] d,
    input logic o, input logic r);
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      in_valid[i]    = v[i];
      in_s[i].tdata  = {16'(i), d};
      in_s[i].tid    = h[i] ? ROUTING_HEADER : 4'h0;
      in_s[i].tdest  = 4'(i);
      in_s[i].tuser  = 4'h0;
      in_s[i].tlast  = l[i];
    end
    out_ready = o;
    rst       = r;
    #1;
  endtask

  task automatic chk(input string name,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, got, exp);
    end
  endtask

  task automatic chk_all(
    input string tag, input logic [N-1:0] e_rdy,
    input logic e_vld, input logic [31:0] e_dat,
    input logic e_last, input logic [3:0] e_gnt,
    input logic [7:0] e_drop);
    chk({tag, ".in_ready"}, 32'(rdy), 32'(e_rdy));
    chk({tag, ".out_valid"}, 32'(out_valid), 32'(e_vld));
    if (e_vld) begin
      chk({tag, ".tdata"}, out.tdata, e_dat);
      chk({tag, ".tlast"}, 32'(out.tlast), 32'(e_last));
    end
    chk({tag, ".grant"}, 32'(current_grant), 32'(e_gnt));
    chk({tag, ".drop"}, 32'(drop_cnt), 32'(e_drop));
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      in_valid[i] = 1'b0;
      in_s[i]     = '0;
    end
    out_ready = 1'b1;
    rst       = 1'b1;

    // v, h, l, d, o | rdy, vld, dat, last, gnt, drop
    tbl[0]  = '{10'h088, 10'h088, 10'h000, 16'h0030, 1'b1,
                10'h000, 1'b0, 32'h0, 1'b0, 4'd9, 8'd0};
    tbl[1]  = '{10'h088, 10'h088, 10'h000, 16'h0030, 1'b1,
                10'h008, 1'b0, 32'h0, 1'b0, 4'd3, 8'd0};
    tbl[2]  = '{10'h088, 10'h080, 10'h000, 16'h0031, 1'b1,
                10'h008, 1'b1, 32'h00030030, 1'b0, 4'd3, 8'd0};
    tbl[3]  = '{10'h088, 10'h080, 10'h000, 16'h0032, 1'b1,
                10'h008, 1'b1, 32'h00030031, 1'b0, 4'd3, 8'd0};
    tbl[4]  = '{10'h088, 10'h080, 10'h008, 16'h0033, 1'b1,
                10'h008, 1'b1, 32'h00030032, 1'b0, 4'd3, 8'd0};
    tbl[5]  = '{10'h080, 10'h080, 10'h000, 16'h0070, 1'b1,
                10'h000, 1'b1, 32'h00030033, 1'b1, 4'd3, 8'd0};
    tbl[6]  = '{10'h080, 10'h080, 10'h000, 16'h0070, 1'b1,
                10'h080, 1'b0, 32'h0, 1'b0, 4'd7, 8'd0};
    tbl[7]  = '{10'h080, 10'h000, 10'h000, 16'h0071, 1'b1,
                10'h080, 1'b1, 32'h00070070, 1'b0, 4'd7, 8'd0};
    tbl[8]  = '{10'h080, 10'h000, 10'h000, 16'h0072, 1'b1,
                10'h080, 1'b1, 32'h00070071, 1'b0, 4'd7, 8'd0};
    tbl[9]  = '{10'h080, 10'h000, 10'h080, 16'h0073, 1'b1,
                10'h080, 1'b1, 32'h00070072, 1'b0, 4'd7, 8'd0};
    tbl[10] = '{10'h000, 10'h000, 10'h000, 16'h0000, 1'b1,
                10'h000, 1'b1, 32'h00070073, 1'b1, 4'd7, 8'd0};
    tbl[11] = '{10'h000, 10'h000, 10'h000, 16'h0000, 1'b1,
                10'h000, 1'b0, 32'h0, 1'b0, 4'd7, 8'd0};
    tbl[12] = '{10'h003, 10'h003, 10'h001, 16'h000A, 1'b1,
                10'h000, 1'b0, 32'h0, 1'b0, 4'd7, 8'd0};
    tbl[13] = '{10'h003, 10'h003, 10'h001, 16'h000A, 1'b1,
                10'h001, 1'b0, 32'h0, 1'b0, 4'd0, 8'd0};
    tbl[14] = '{10'h002, 10'h002, 10'h002, 16'h0010, 1'b1,
                10'h000, 1'b1, 32'h0000000A, 1'b1, 4'd0, 8'd0};
    tbl[15] = '{10'h002, 10'h002, 10'h002, 16'h0010, 1'b1,
                10'h002, 1'b0, 32'h0, 1'b0, 4'd1, 8'd0};
    tbl[16] = '{10'h000, 10'h000, 10'h000, 16'h0000, 1'b1,
                10'h000, 1'b1, 32'h00010010, 1'b1, 4'd1, 8'd0};
    tbl[17] = '{10'h020, 10'h000, 10'h000, 16'h0055, 1'b1,
                10'h020, 1'b0, 32'h0, 1'b0, 4'd1, 8'd0};
    tbl[18] = '{10'h034, 10'h004, 10'h000, 16'h0020, 1'b1,
                10'h030, 1'b0, 32'h0, 1'b0, 4'd1, 8'd1};
    tbl[19] = '{10'h014, 10'h004, 10'h000, 16'h0020, 1'b1,
                10'h004, 1'b0, 32'h0, 1'b0, 4'd2, 8'd3};

    repeat (2) @(posedge clk);

    for (int k = 0; k < 20; k++) begin
      drive(tbl[k].v, tbl[k].h, tbl[k].l, tbl[k].d, tbl[k].o, 1'b0);
      chk_all($sformatf("vec%0d", k), tbl[k].e_rdy, tbl[k].e_vld,
              tbl[k].e_dat, tbl[k].e_last, tbl[k].e_gnt,
              tbl[k].e_drop);
    end

    // ch2 header sits in the output register; stall downstream
    for (int k = 0; k < 5; k++) begin
      drive(10'h004, 10'h000, 10'h000, 16'h0021, 1'b0, 1'b0);
      chk_all($sformatf("stall%0d", k), 10'h000, 1'b1,
              32'h00020020, 1'b0, 4'd2, 8'd3);
    end
    drive(10'h004, 10'h000, 10'h000, 16'h0021, 1'b1, 1'b0);
    chk_all("resume", 10'h004, 1'b1, 32'h00020020, 1'b0, 4'd2, 8'd3);
    drive(10'h004, 10'h000, 10'h004, 16'h0022, 1'b1, 1'b0);
    chk_all("flit2", 10'h004, 1'b1, 32'h00020021, 1'b0, 4'd2, 8'd3);
    drive(10'h000, 10'h000, 10'h000, 16'h0000, 1'b1, 1'b0);
    chk_all("tail", 10'h000, 1'b1, 32'h00020022, 1'b1, 4'd2, 8'd3);
    drive(10'h000, 10'h000, 10'h000, 16'h0000, 1'b1, 1'b0);
    chk_all("drained", 10'h000, 1'b0, 32'h0, 1'b0, 4'd2, 8'd3);

    // drop counter: three in one cycle, then saturation
    drive(10'h000, 10'h000, 10'h000, 16'h0000, 1'b1, 1'b1);
    drive(10'h070, 10'h000, 10'h000, 16'h0055, 1'b1, 1'b0);
    chk_all("multi_drop", 10'h070, 1'b0, 32'h0, 1'b0, 4'd9, 8'd0);
    drive(10'h020, 10'h000, 10'h000, 16'h0055, 1'b1, 1'b0);
    chk_all("drop3", 10'h020, 1'b0, 32'h0, 1'b0, 4'd9, 8'd3);
    for (int k = 0; k < 250; k++) begin
      drive(10'h020, 10'h000, 10'h000, 16'h0055, 1'b1, 1'b0);
      chk("sat_rdy", 32'(rdy), 32'h020);
    end
    drive(10'h020, 10'h000, 10'h000, 16'h0055, 1'b1, 1'b0);
    chk_all("drop254", 10'h020, 1'b0, 32'h0, 1'b0, 4'd9, 8'd254);
    for (int k = 0; k < 48; k++) begin
      drive(10'h020, 10'h000, 10'h000, 16'h0055, 1'b1, 1'b0);
    end
    drive(10'h000, 10'h000, 10'h000, 16'h0000, 1'b1, 1'b0);
    chk_all("drop_sat", 10'h000, 1'b0, 32'h0, 1'b0, 4'd9, 8'd255);

    // reset during the third flit of a ch1 packet
    drive(10'h002, 10'h002, 10'h000, 16'h0040, 1'b1, 1'b0);
    chk_all("r_arb", 10'h000, 1'b0, 32'h0, 1'b0, 4'd9, 8'd255);
    drive(10'h002, 10'h002, 10'h000, 16'h0040, 1'b1, 1'b0);
    chk_all("r_hdr", 10'h002, 1'b0, 32'h0, 1'b0, 4'd1, 8'd255);
    drive(10'h002, 10'h000, 10'h000, 16'h0041, 1'b1, 1'b0);
    chk_all("r_f1", 10'h002, 1'b1, 32'h00010040, 1'b0, 4'd1, 8'd255);
    drive(10'h002, 10'h000, 10'h000, 16'h0042, 1'b1, 1'b1);
    chk_all("r_rst", 10'h000, 1'b1, 32'h00010041, 1'b0, 4'd1, 8'd255);
    drive(10'h000, 10'h000, 10'h000, 16'h0000, 1'b1, 1'b0);
    chk_all("r_after", 10'h000, 1'b0, 32'h0, 1'b0, 4'd9, 8'd0);
    drive(10'h002, 10'h000, 10'h000, 16'h0043, 1'b1, 1'b0);
    chk_all("r_idle", 10'h002, 1'b0, 32'h0, 1'b0, 4'd9, 8'd0);

    // pointer at 9: next search wraps to channel 0
    drive(10'h200, 10'h200, 10'h200, 16'h0090, 1'b1, 1'b0);
    chk_all("w_arb9", 10'h000, 1'b0, 32'h0, 1'b0, 4'd9, 8'd1);
    drive(10'h200, 10'h200, 10'h200, 16'h0090, 1'b1, 1'b0);
    chk_all("w_lock9", 10'h200, 1'b0, 32'h0, 1'b0, 4'd9, 8'd1);
    drive(10'h201, 10'h201, 10'h201, 16'h00A0, 1'b1, 1'b0);
    chk_all("w_both", 10'h000, 1'b1, 32'h00090090, 1'b1, 4'd9, 8'd1);
    drive(10'h201, 10'h201, 10'h201, 16'h00A0, 1'b1, 1'b0);
    chk_all("w_wrap", 10'h001, 1'b0, 32'h0, 1'b0, 4'd0, 8'd1);
    drive(10'h000, 10'h000, 10'h000, 16'h0000, 1'b1, 1'b0);
    chk_all("w_done", 10'h000, 1'b1, 32'h000000A0, 1'b1, 4'd0, 8'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
